// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the randomizer share controller
package rng_pkg;

    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } rng_state_e;

    localparam int RNG_WIDTH = 16;
    localparam logic [RNG_WIDTH-1:0] DEFAULT_SEED = 16'h4242;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search over the request vector
//   req    : per-consumer request bits
//   rr_ptr : index where the upward, wrapping search starts
//   any    : at least one request bit set
//   winner : index of the first set request at or after rr_ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic             any,
    output logic [PW-1:0]    winner
);

    logic [PW-1:0] idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % N_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - seeds the shared LFSR and hands its samples to consumers round-robin
//   clk, rst   : clock, synchronous active-high reset
//   seed_load  : reseed request, aborts arbitration in that cycle
//   req        : per-consumer request, held until granted
//   rng_out    : current LFSR word
//   rng_start  : 1 = LFSR loads/holds seed, 0 = LFSR runs
//   grant      : one-hot single-cycle grant
//   rnd_valid  : high together with any grant bit
//   rnd_data   : sample delivered with the grant, held between grants
//   busy       : high while seeding or warming up
module rng_share_ctrl
    import rng_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = RNG_WIDTH,
    parameter int GAP      = 4,
    parameter int SEED_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] rng_out,
    output logic             rng_start,
    output logic [N_REQ-1:0] grant,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    output logic             busy
);

    localparam int PW  = $clog2(N_REQ);
    localparam int SCW = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;
    localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

    rng_state_e       state, state_n;
    logic [SCW-1:0]   seed_cnt, seed_cnt_n;
    logic [GCW-1:0]   gap_cnt, gap_cnt_n;
    logic [PW-1:0]    rr_ptr, rr_ptr_n;
    logic [N_REQ-1:0] grant_n;
    logic [WIDTH-1:0] rnd_data_n;
    logic             any;
    logic [PW-1:0]    winner;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        state_n    = state;
        seed_cnt_n = seed_cnt;
        gap_cnt_n  = gap_cnt;
        rr_ptr_n   = rr_ptr;
        grant_n    = '0;
        rnd_data_n = rnd_data;
        if (seed_load) begin
            // Reseed wins over arbitration; pointer and last sample survive.
            state_n    = SEED;
            seed_cnt_n = '0;
        end else begin
            case (state)
                SEED: begin
                    if (seed_cnt == SCW'(SEED_CYC - 1)) begin
                        state_n   = WARM;
                        gap_cnt_n = GCW'(GAP - 1);
                    end else begin
                        seed_cnt_n = seed_cnt + SCW'(1);
                    end
                end
                WARM: begin
                    if (gap_cnt == '0) state_n = RUN;
                    else               gap_cnt_n = gap_cnt - GCW'(1);
                end
                RUN: begin
                    if (gap_cnt == '0 && any) begin
                        grant_n    = N_REQ'(1) << winner;
                        rnd_data_n = rng_out;
                        rr_ptr_n   = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
                        gap_cnt_n  = GCW'(GAP - 1);
                    end else if (gap_cnt != '0) begin
                        gap_cnt_n = gap_cnt - GCW'(1);
                    end
                end
                default: state_n = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEED;
            seed_cnt  <= '0;
            gap_cnt   <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            rng_start <= 1'b1;
            busy      <= 1'b1;
        end else begin
            state     <= state_n;
            seed_cnt  <= seed_cnt_n;
            gap_cnt   <= gap_cnt_n;
            rr_ptr    <= rr_ptr_n;
            grant     <= grant_n;
            rnd_valid <= |grant_n;
            rnd_data  <= rnd_data_n;
            // Outputs follow the state being entered so they line up with it.
            rng_start <= (state_n == SEED);
            busy      <= (state_n != RUN);
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb/tb_rng_share_ctrl.sv - self-checking bench for rng_share_ctrl
module tb_rng_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         seed_load = 1'b0;
    logic [N-1:0] req = '1;

    logic [W-1:0] rng    [2] = '{16'h0, 16'h0};
    logic         rstart [2];
    logic [N-1:0] grant  [2];
    logic         valid  [2];
    logic [W-1:0] data   [2];
    logic         busy   [2];

    rng_share_ctrl #(.N_REQ(N), .WIDTH(W), .GAP(4), .SEED_CYC(SC)) dut0 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .req(req), .rng_out(rng[0]),
        .rng_start(rstart[0]), .grant(grant[0]), .rnd_valid(valid[0]),
        .rnd_data(data[0]), .busy(busy[0])
    );

    rng_share_ctrl #(.N_REQ(N), .WIDTH(W), .GAP(1), .SEED_CYC(SC)) dut1 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .req(req), .rng_out(rng[1]),
        .rng_start(rstart[1]), .grant(grant[1]), .rnd_valid(valid[1]),
        .rnd_data(data[1]), .busy(busy[1])
    );

    // Randomizer stand-in: Galois LFSR, seed held while start is high.
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {1'b0, s[W-1:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            rng[k] <= rstart[k] ? 16'h4242 : lfsr_next(rng[k]);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: timestamp-based. seed_e is the edge that (re)started seeding;
    // a grant may issue at edge e when the block was already running before e,
    // at least GAP edges have passed since the last pulse, and someone requests.
    int           cyc = 0;
    int           seed_e [2] = '{0, 0};
    int           last_p [2] = '{-1000, -1000};
    int           ptr    [2] = '{0, 0};
    logic [N-1:0] eg [2];
    logic         ev [2];
    logic [W-1:0] ed [2];
    logic         eb [2];
    logic         es [2];
    logic [W-1:0] mdata [$];

    function automatic int gap_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            eg[k] = '0;
            ev[k] = 1'b0;
            if (rst) begin
                seed_e[k] = cyc;
                ptr[k]    = 0;
                ed[k]     = '0;
                last_p[k] = -1000;
            end else if (seed_load) begin
                seed_e[k] = cyc;
            end else if (cyc - 1 >= seed_e[k] + SC + gap_of(k) &&
                         cyc >= last_p[k] + gap_of(k) && req != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (!ev[k] && req[(ptr[k] + i) % N]) begin
                        ev[k] = 1'b1;
                        eg[k] = N'(1) << ((ptr[k] + i) % N);
                        ptr[k] = (ptr[k] + i + 1) % N;
                    end
                end
                ed[k]     = rng[k];
                last_p[k] = cyc;
                if (k == 0) mdata.push_back(rng[0]);
            end
            eb[k] = (cyc < seed_e[k] + SC + gap_of(k));
            es[k] = (cyc < seed_e[k] + SC);
        end
    end

    // Per-cycle comparison against the model plus grant event logs.
    logic         mon_en = 1'b0;
    int           st_cnt = 0;
    int           busy_cnt = 0;
    logic [N-1:0] qg0 [$];
    logic [N-1:0] qg1 [$];
    int           qt0 [$];
    int           qt1 [$];
    logic [W-1:0] qd0 [$];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("grant%0d", k), grant[k], eg[k]);
                chk($sformatf("valid%0d", k), valid[k], ev[k]);
                chk($sformatf("data%0d", k), data[k], ed[k]);
                chk($sformatf("busy%0d", k), busy[k], eb[k]);
                chk($sformatf("rng_start%0d", k), rstart[k], es[k]);
            end
            if (grant[0] != '0) begin
                qg0.push_back(grant[0]); qt0.push_back(cyc); qd0.push_back(data[0]);
            end
            if (grant[1] != '0) begin
                qg1.push_back(grant[1]); qt1.push_back(cyc);
            end
            if (rstart[0] && !rst) st_cnt++;
            if (busy[0] && !rst) busy_cnt++;
        end
    end

    task automatic step(input logic r, input logic s, input logic [N-1:0] q);
        rst = r; seed_load = s; req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        qg0.delete(); qg1.delete(); qt0.delete(); qt1.delete(); qd0.delete();
        mdata.delete(); st_cnt = 0; busy_cnt = 0;
    endtask

    task automatic wait_pulse0(input logic [N-1:0] q);
        int n = 0;
        do begin
            step(1'b0, 1'b0, q);
            n++;
        end while (grant[0] == '0 && n < 40);
        chk("wait_pulse", grant[0] != '0, 1);
    endtask

    logic [W-1:0] ref_d [4];
    int e0;

    initial begin
        // Test 1/2: reset, all four requesting from the start.
        step(1'b1, 1'b0, '1);
        mon_en = 1'b1;
        step(1'b1, 1'b0, '1);
        e0 = cyc;
        clear_logs();
        repeat (30) step(1'b0, 1'b0, '1);
        chk("seed_cycles", st_cnt, 2);
        chk("busy_cycles", busy_cnt, 6);
        chk("p1_count", qg0.size() >= 5, 1);
        chk("p1_model_count", mdata.size() >= 4, 1);
        if (qg0.size() >= 5 && mdata.size() >= 4) begin
            chk("p1_first_lat", qt0[0] - e0, 7);
            for (int i = 0; i < 5; i++) chk($sformatf("p1_grant%0d", i), qg0[i], 1 << (i % 4));
            for (int i = 1; i < 5; i++) chk("p1_spacing", qt0[i] - qt0[i-1], 4);
            for (int i = 0; i < 4; i++) ref_d[i] = mdata[i];
            for (int i = 0; i < 4; i++)
                for (int j = i + 1; j < 4; j++) chk("p1_distinct", qd0[i] != qd0[j], 1);
        end

        // Test 3: single requester, then a lower index joins.
        clear_logs();
        repeat (20) step(1'b0, 1'b0, 4'b0100);
        chk("p3_count", qg0.size() >= 4, 1);
        for (int i = 0; i < qg0.size(); i++) chk("p3_grant", qg0[i], 4'b0100);
        for (int i = 1; i < qg0.size(); i++) chk("p3_spacing", qt0[i] - qt0[i-1], 4);
        wait_pulse0(4'b0101);
        chk("p3_wrap", grant[0], 4'b0001);

        // Test 4: reseed on an eligible cycle.
        wait_pulse0('1);
        repeat (3) step(1'b0, 1'b0, '1);
        clear_logs();
        step(1'b0, 1'b1, '1);
        e0 = cyc;
        chk("p4_nogrant", grant[0], 0);
        repeat (30) step(1'b0, 1'b0, '1);
        chk("p4_seed_cycles", st_cnt, 2);
        chk("p4_busy_cycles", busy_cnt, 6);
        chk("p4_count", qd0.size() >= 4, 1);
        if (qd0.size() >= 4) begin
            chk("p4_first_lat", qt0[0] - e0, 7);
            for (int i = 0; i < 4; i++) chk($sformatf("p4_repeat%0d", i), qd0[i], ref_d[i]);
        end

        // Test 5: GAP=1 instance, two requesters back to back.
        step(1'b1, 1'b0, 4'b0011);
        clear_logs();
        repeat (20) step(1'b0, 1'b0, 4'b0011);
        chk("p5_count", qg1.size() >= 4, 1);
        if (qg1.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("p5_grant%0d", i), qg1[i], (i % 2 == 0) ? 1 : 2);
            for (int i = 1; i < 4; i++) chk("p5_spacing", qt1[i] - qt1[i-1], 1);
        end

        // Test 6: reset on a cycle where a grant would issue.
        wait_pulse0('1);
        repeat (3) step(1'b0, 1'b0, '1);
        step(1'b1, 1'b0, '1);
        chk("p6_grant", grant[0], 0);
        chk("p6_valid", valid[0], 0);
        chk("p6_data", data[0], 0);
        chk("p6_busy", busy[0], 1);
        chk("p6_rng_start", rstart[0], 1);
        clear_logs();
        repeat (30) step(1'b0, 1'b0, '1);
        chk("p6_count", qd0.size() >= 4, 1);
        if (qd0.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("p6_repeat%0d", i), qd0[i], ref_d[i]);

        // Random traffic against the model.
        repeat (600)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, N'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rng_share_ctrl.md
Name: rng_share_ctrl

Overview:
Controller that seeds and sequences the shared 16-bit Randomizer LFSR and shares its output among N_REQ consumers, such as agent action selectors and exploration logic. It drives the Randomizer's seed-load control and arbitrates consumer requests round-robin. It enforces a minimum LFSR-step spacing between handed-out samples so successive consumers never see correlated values. It is instantiated next to Randomizer in the top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, random word width; must match Randomizer
GAP, 4, minimum clock cycles between consecutive grants (>=1); also the warm-up length after seeding
SEED_CYC, 2, cycles rng_start is held high to load the seed (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
seed_load  in  1  pulse: reseed Randomizer from its seed input; aborts pending arbitration
req  in  N_REQ  per-consumer request; held until granted
rng_out  in  WIDTH  Randomizer output
rng_start  out  1  to Randomizer start: 1 = load/hold seed, 0 = run
grant  out  N_REQ  one-hot, one-cycle grant pulse
rnd_valid  out  1  high with any grant bit
rnd_data  out  WIDTH  sample delivered with grant; holds between grants
busy  out  1  high in SEED and WARM states

Behaviour:
- Reset (rst=1 at a clk edge): state=SEED, rng_start=1, grant=0, rnd_valid=0, rnd_data=0, rr_ptr=0, seed_cnt=0, gap_cnt=0, busy=1. Reset overrides everything, including a grant that would occur in the same cycle.
- State machine:
  - SEED:
    - rng_start=1.
    - seed_cnt counts up to SEED_CYC-1, then goes to WARM with gap_cnt=GAP-1.
  - WARM:
    - rng_start=0; LFSR steps each cycle.
    - gap_cnt decrements each cycle; at 0 goes to RUN.
    - Requests are ignored.
  - RUN:
    - rng_start=0, busy=0.
    - The cycle is eligible when gap_cnt==0 and |req.
    - On an eligible cycle, winner = first set req bit searching upward from rr_ptr, wrapping.
    - Next edge: grant=onehot(winner), rnd_valid=1, rnd_data=rng_out sampled in the decision cycle, rr_ptr=(winner+1) mod N_REQ, gap_cnt=GAP-1.
    - Otherwise: gap_cnt decrements, saturating at 0, and grant=0.
- Grant spacing: if a grant pulse occurs at cycle t, the next pulse occurs no earlier than t+GAP. GAP=1 allows back-to-back grants.
- Deasserting req before grant is legal: that bit is skipped. There is no request queueing.
- seed_load:
  - Valid in any state; takes priority over arbitration in the same cycle (no grant issued).
  - Next edge: state=SEED, seed_cnt=0, rng_start=1.
  - rr_ptr and rnd_data are kept.
  - seed_load during SEED restarts the seed count.
- Width: rnd_data is the full WIDTH bits, untouched. Consumers interpret bits as an unsigned fraction (e.g. [7:0]*2^-8).
- All outputs are registered. Latency from req to grant is 1 cycle when eligible.

Decomposition:
- Package rng_pkg:
  - state enum {SEED, WARM, RUN}
  - RNG_WIDTH=16
  - DEFAULT_SEED=16'h4242
- Sub-module rr_arbiter(N_REQ):
  - Combinational inputs: req, rr_ptr.
  - Outputs: any, winner index.
- Pointer, counters and FSM stay in rng_share_ctrl. Randomizer is instantiated at the top level, not inside this block.

Test Plan:
1. Defaults; reset, Randomizer seed 16'h4242, req=4'b1111 from the first cycle -> rng_start=1 for exactly 2 cycles after reset release, then 0; no grant during the 4 WARM cycles; first grant=4'b0001.
2. req=4'b1111 held in RUN -> grants 0001,0010,0100,1000,0001 exactly 4 cycles apart. Each rnd_data equals the rng_out value from the cycle before its pulse, and the values are pairwise distinct.
3. req=4'b0100 only -> grant=4'b0100 every 4 cycles. Then add req[0] -> it wins next, because rr_ptr=3 wraps to 0.
4. seed_load pulsed in RUN on an eligible cycle with req pending -> no grant that cycle; rng_start=1 for 2 cycles, busy=1 for 6 cycles; the rnd_data sequence after reseed repeats the post-reset sequence.
5. GAP=1, req=4'b0011 held -> back-to-back grants 0001,0010,0001,0010.
6. rst asserted on a cycle where a grant would issue -> grant stays 0, all outputs at reset values the next cycle, the seed sequence restarts.
